decode_stage_p: RTL
===================

// Module: decode_stage_p
// PURPOSE
//  Parametrised MIPS decode stage. Contains the IF/ID pipeline register, register file, main/ALU control decoder,
//  early branch/jump resolution with MEM-stage forwarding, and the ID/EX pipeline register.
//  Sits between fetch and execute; stall/flush/forward selects come from the hazard unit.
// PARAMETERS
//  DATA_W  32  register/datapath width (>=32); immediate sign-extended to DATA_W
//  PC_W    32  program-counter width (>=28)
//  NREGS   32  implemented registers (2..32); r0 hardwired to zero
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        async active-high reset
//  stall_d      in   1        hold IF/ID register; pc_src_d forced 0
//  flush_e      in   1        load bubble into ID/EX on next edge
//  instr_f      in   32       fetched instruction
//  pc_plus4_f   in   PC_W     fetch PC+4
//  wb_we        in   1        writeback enable
//  wb_addr      in   5        writeback register
//  wb_data      in   DATA_W   writeback data
//  fwd_a_d      in   1        comparator A uses alu_out_m instead of rd1
//  fwd_b_d      in   1        comparator B uses alu_out_m instead of rd2
//  alu_out_m    in   DATA_W   MEM-stage ALU result
//  rs_d         out  5        instr_d[25:21], to hazard unit
//  rt_d         out  5        instr_d[20:16], to hazard unit
//  branch_d     out  1        decoded beq in ID
//  pc_src_d     out  1        redirect fetch: (beq & equal) | j, gated by ~stall_d
//  pc_target_d  out  PC_W     branch target, or jump target if j
//  illegal_d    out  1        unsupported opcode/funct in ID
//  ctrl_e       out  9        {reg_write,mem_to_reg,mem_write,alu_ctrl[2:0],alu_src,reg_dst,syscall}
//  rd1_e        out  DATA_W   registered rs data
//  rd2_e        out  DATA_W   registered rt data
//  rs_e/rt_e/rd_e out 5 each  registered register fields
//  imm_e        out  DATA_W   registered sign-extended immediate
// BEHAVIOUR
//  Reset: instr_d=0 (nop), pc_plus4_d=0, all registers=0, every ID/EX output 0; D outputs follow from nop (all 0).
//  IF/ID per edge, priority: pc_src_d -> instr_d=0 (flush); else stall_d -> hold; else load instr_f/pc_plus4_f.
//  ID/EX per edge: flush_e -> all fields 0 (bubble); else capture ID values. No stall on ID/EX. Latency ID->EX = 1 cycle.
//  Regfile: write on rising edge if wb_we & wb_addr!=0 & wb_addr<NREGS. Reads combinational, with write-through:
//   read addr==wb_addr, wb_we, addr!=0 -> wb_data same cycle. Addr 0 or >=NREGS reads 0.
//  Decode (opcode / funct -> alu_ctrl): R-type 0x00: add 0x20->010, sub 0x22->110, and 0x24->000, or 0x25->001,
//   slt 0x2A->111 (reg_write=1, reg_dst=1); syscall funct 0x0C -> syscall=1 only.
//   lw 0x23: reg_write,mem_to_reg,alu_src, alu 010. sw 0x2B: mem_write,alu_src, alu 010. addi 0x08: reg_write,alu_src, alu 010.
//   beq 0x04: branch_d, alu 110. j 0x02: jump. Anything else: ctrl all 0, illegal_d=1.
//  imm = sign-extend instr_d[15:0] to DATA_W. pc_branch = pc_plus4_d + (imm<<2) truncated to PC_W (wraps mod 2^PC_W).
//  jump target = {pc_plus4_d[PC_W-1:28], instr_d[25:0], 2'b00}.
//  equal = (fwd_a_d ? alu_out_m : rd1) == (fwd_b_d ? alu_out_m : rd2), full DATA_W compare.
//  stall_d & pc_src condition simultaneously: pc_src_d=0, IF/ID held (branch re-evaluated once unstalled).
//  Reset asserted mid-operation: all state cleared immediately (async); first edge after release loads normally.
// TESTING
//  Reset mid-stream -> ctrl_e=0, rd1_e=0, instr_d nop, every register reads 0 on the next cycle.
//  wb write r5=0xDEADBEEF while decoding add $3,$5,$0 -> rd1_e=0xDEADBEEF (write-through); write r0=7 -> r0 reads 0.
//  beq $1,$2,+3 with r1=r2=9, pc_plus4=0x100 -> pc_src_d=1, pc_target_d=0x10C, instr_d=0 next edge; beq imm=-1 -> 0x0FC.
//  beq with rd1=4, alu_out_m=9, rd2=9, fwd_a_d=1 -> pc_src_d=1; same with stall_d=1 -> pc_src_d=0, instr_d held.
//  lw then flush_e=1 -> ctrl_e=0 and rd1_e/rd2_e/imm_e=0; stall_d=1 for 2 cycles -> instr_d unchanged.
//  NREGS=8, DATA_W=64: write r12 ignored and reads 0; addi imm 0x8000 -> imm_e=0xFFFFFFFFFFFF8000; opcode 0x3F -> illegal_d=1.

Source files
------------

// File: rtl/decode_stage_p.sv
// MIPS decode stage: IF/ID register, register file, control decode, early branch/jump
// resolution with MEM-stage forwarding into the comparator, and the ID/EX register.
module decode_stage_p #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_d,
    input  logic              flush_e,
    input  logic [31:0]       instr_f,
    input  logic [PC_W-1:0]   pc_plus4_f,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              fwd_a_d,
    input  logic              fwd_b_d,
    input  logic [DATA_W-1:0] alu_out_m,
    output logic [4:0]        rs_d,
    output logic [4:0]        rt_d,
    output logic              branch_d,
    output logic              pc_src_d,
    output logic [PC_W-1:0]   pc_target_d,
    output logic              illegal_d,
    output logic [8:0]        ctrl_e,
    output logic [DATA_W-1:0] rd1_e,
    output logic [DATA_W-1:0] rd2_e,
    output logic [4:0]        rs_e,
    output logic [4:0]        rt_e,
    output logic [4:0]        rd_e,
    output logic [DATA_W-1:0] imm_e
);
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic [PC_W-1:0]   if_id_pc4_q, if_id_pc4_d;
    logic [DATA_W-1:0] rf_q [1:NREGS-1];
    logic [DATA_W-1:0] rd1, rd2, imm, cmp_a, cmp_b;
    logic [PC_W-1:0]   imm_pc, pc_branch, jump_target;
    logic [8:0]        ctrl;
    logic              jump, wb_hit;
    logic [5:0]        opcode, funct;

    assign opcode = if_id_instr_q[31:26];
    assign funct  = if_id_instr_q[5:0];
    assign rs_d   = if_id_instr_q[25:21];
    assign rt_d   = if_id_instr_q[20:16];

    // IF/ID: a taken redirect squashes the slot; otherwise stall holds it.
    always_comb begin
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if (pc_src_d) begin
            if_id_instr_d = '0;
            if_id_pc4_d   = '0;
        end else if (!stall_d) begin
            if_id_instr_d = instr_f;
            if_id_pc4_d   = pc_plus4_f;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_instr_q <= '0;
            if_id_pc4_q   <= '0;
        end else begin
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
        end
    end

    for (genvar gi = 1; gi < NREGS; gi++) begin : g_rf
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rf_q[gi] <= '0;
            else if (wb_we && wb_addr == 5'(gi)) rf_q[gi] <= wb_data;
        end
    end

    // Write-through lets a same-cycle writeback reach the reader without a bypass stall.
    assign wb_hit = wb_we && (wb_addr != 5'd0) && (int'(wb_addr) < NREGS);

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (rs_d == 5'(i)) rd1 = rf_q[i];
            if (rt_d == 5'(i)) rd2 = rf_q[i];
        end
        if (wb_hit && wb_addr == rs_d) rd1 = wb_data;
        if (wb_hit && wb_addr == rt_d) rd2 = wb_data;
    end

    // ctrl = {reg_write, mem_to_reg, mem_write, alu_ctrl, alu_src, reg_dst, syscall}
    always_comb begin
        ctrl      = '0;
        branch_d  = 1'b0;
        jump      = 1'b0;
        illegal_d = 1'b0;
        case (opcode)
            6'h00: begin
                if (if_id_instr_q != 32'd0) begin
                    case (funct)
                        6'h20:   ctrl = {3'b100, ALU_ADD, 3'b010};
                        6'h22:   ctrl = {3'b100, ALU_SUB, 3'b010};
                        6'h24:   ctrl = {3'b100, ALU_AND, 3'b010};
                        6'h25:   ctrl = {3'b100, ALU_OR,  3'b010};
                        6'h2A:   ctrl = {3'b100, ALU_SLT, 3'b010};
                        6'h0C:   ctrl = 9'b000_000_001;
                        default: illegal_d = 1'b1;
                    endcase
                end
            end
            6'h23: ctrl = {3'b110, ALU_ADD, 3'b100};
            6'h2B: ctrl = {3'b001, ALU_ADD, 3'b100};
            6'h08: ctrl = {3'b100, ALU_ADD, 3'b100};
            6'h04: begin
                ctrl     = {3'b000, ALU_SUB, 3'b000};
                branch_d = 1'b1;
            end
            6'h02:   jump = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    assign imm       = {{(DATA_W-16){if_id_instr_q[15]}}, if_id_instr_q[15:0]};
    assign imm_pc    = {{(PC_W-16){if_id_instr_q[15]}}, if_id_instr_q[15:0]};
    assign pc_branch = if_id_pc4_q + (imm_pc << 2);

    if (PC_W > 28) begin : g_jt_wide
        assign jump_target = {if_id_pc4_q[PC_W-1:28], if_id_instr_q[25:0], 2'b00};
    end else begin : g_jt_narrow
        assign jump_target = {if_id_instr_q[25:0], 2'b00};
    end

    assign cmp_a       = fwd_a_d ? alu_out_m : rd1;
    assign cmp_b       = fwd_b_d ? alu_out_m : rd2;
    assign pc_src_d    = ((branch_d && (cmp_a == cmp_b)) || jump) && !stall_d;
    assign pc_target_d = jump ? jump_target : pc_branch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_e) begin
            ctrl_e <= '0;
            rd1_e  <= '0;
            rd2_e  <= '0;
            rs_e   <= '0;
            rt_e   <= '0;
            rd_e   <= '0;
            imm_e  <= '0;
        end else begin
            ctrl_e <= ctrl;
            rd1_e  <= rd1;
            rd2_e  <= rd2;
            rs_e   <= rs_d;
            rt_e   <= rt_d;
            rd_e   <= if_id_instr_q[15:11];
            imm_e  <= imm;
        end
    end
endmodule
